// File: rtl/body_rate_controller.sv
// Body-rate PI(D) stage: per-axis rate loop between the angle controller
// and the motor mixer, one iteration per start request.
module body_rate_controller #(
  parameter int KP_MULT         = 8,
  parameter int KP_SHIFT        = 3,
  parameter int KI_MULT         = 1,
  parameter int KI_SHIFT        = 6,
  parameter int KD_MULT         = 0,
  parameter int KD_SHIFT        = 0,
  parameter int INT_LIMIT       = 2000,
  parameter int OUT_LIMIT       = 4000,
  parameter int THROTTLE_MAX    = 4000,
  parameter int INT_EN_THROTTLE = 480
) (
  input  logic        us_clk,
  input  logic        resetn,
  input  logic        start_signal,
  input  logic [15:0] throttle_rate_in,
  input  logic [15:0] yaw_rate_target,
  input  logic [15:0] pitch_rate_target,
  input  logic [15:0] roll_rate_target,
  input  logic [15:0] yaw_rate_actual,
  input  logic [15:0] pitch_rate_actual,
  input  logic [15:0] roll_rate_actual,
  output logic [15:0] throttle_out,
  output logic [15:0] yaw_out,
  output logic [15:0] pitch_out,
  output logic [15:0] roll_out,
  output logic        active_signal,
  output logic        complete_signal
);

  localparam logic signed [31:0] KP   = KP_MULT;
  localparam logic signed [31:0] KI   = KI_MULT;
  localparam logic signed [31:0] KD   = KD_MULT;
  localparam logic signed [31:0] ILIM = INT_LIMIT;
  localparam logic signed [31:0] OLIM = OUT_LIMIT;
  localparam logic signed [31:0] TMAX = THROTTLE_MAX;
  localparam logic signed [31:0] TEN  = INT_EN_THROTTLE;

  typedef enum logic [2:0] {
    S_WAIT,
    S_LATCH,
    S_ERROR,
    S_TERMS,
    S_SUM,
    S_LIMIT,
    S_COMPLETE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic start_q;
  logic start_edge;
  logic pending;
  logic pending_nxt;

  logic signed [15:0] thr_l;
  logic signed [31:0] thr_x;
  logic signed [15:0] tgt    [3];
  logic signed [15:0] act    [3];
  logic signed [31:0] err    [3];
  logic signed [31:0] e_prev [3];
  logic signed [31:0] p_t    [3];
  logic signed [31:0] i_acc  [3];
  logic signed [31:0] d_t    [3];
  logic signed [31:0] u      [3];
  logic signed [31:0] p_c    [3];
  logic signed [31:0] i_c    [3];
  logic signed [31:0] d_c    [3];
  logic        [15:0] axis_q [3];
  logic int_en;

  function automatic logic signed [31:0] clamp32(
    input logic signed [31:0] v,
    input logic signed [31:0] lim
  );
    if (v > lim)
      return lim;
    else if (v < -lim)
      return -lim;
    else
      return v;
  endfunction

  function automatic logic [15:0] sat16(
    input logic signed [31:0] v
  );
    logic signed [31:0] c;
    c = clamp32(v, OLIM);
    return 16'(c);
  endfunction

  assign start_edge = start_signal & ~start_q;
  assign thr_x      = {{16{thr_l[15]}}, thr_l};
  assign int_en     = (thr_x >= TEN);

  assign yaw_out   = axis_q[0];
  assign pitch_out = axis_q[1];
  assign roll_out  = axis_q[2];

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    unique case (state)
      S_WAIT:     if (start_edge) state_nxt = S_LATCH;
      S_LATCH:    state_nxt = S_ERROR;
      S_ERROR:    state_nxt = S_TERMS;
      S_TERMS:    state_nxt = S_SUM;
      S_SUM:      state_nxt = S_LIMIT;
      S_LIMIT:    state_nxt = S_COMPLETE;
      S_COMPLETE: begin
        if (pending || start_edge) begin
          state_nxt   = S_LATCH;
          pending_nxt = 1'b0;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      default:    state_nxt = S_WAIT;
    endcase
    // Edges mid-run queue one follow-up run; extra ones are dropped
    if (start_edge && state != S_WAIT && state != S_COMPLETE)
      pending_nxt = 1'b1;
  end

  always_comb begin
    for (int a = 0; a < 3; a++) begin
      p_c[a] = (err[a] * KP) >>> KP_SHIFT;
      i_c[a] = clamp32(i_acc[a] + ((err[a] * KI) >>> KI_SHIFT), ILIM);
      d_c[a] = ((err[a] - e_prev[a]) * KD) >>> KD_SHIFT;
    end
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state           <= S_WAIT;
      pending         <= 1'b0;
      start_q         <= 1'b0;
      active_signal   <= 1'b0;
      complete_signal <= 1'b0;
      thr_l           <= '0;
      throttle_out    <= '0;
      for (int a = 0; a < 3; a++) begin
        tgt[a]    <= '0;
        act[a]    <= '0;
        err[a]    <= '0;
        e_prev[a] <= '0;
        p_t[a]    <= '0;
        i_acc[a]  <= '0;
        d_t[a]    <= '0;
        u[a]      <= '0;
        axis_q[a] <= '0;
      end
    end else begin
      state           <= state_nxt;
      pending         <= pending_nxt;
      start_q         <= start_signal;
      active_signal   <= (state_nxt != S_WAIT) && (state_nxt != S_COMPLETE);
      complete_signal <= (state == S_LIMIT);
      case (state)
        S_LATCH: begin
          thr_l  <= throttle_rate_in;
          tgt[0] <= yaw_rate_target;
          tgt[1] <= pitch_rate_target;
          tgt[2] <= roll_rate_target;
          act[0] <= yaw_rate_actual;
          act[1] <= pitch_rate_actual;
          act[2] <= roll_rate_actual;
        end
        S_ERROR: begin
          for (int a = 0; a < 3; a++)
            err[a] <= {{16{tgt[a][15]}}, tgt[a]}
                    - {{16{act[a][15]}}, act[a]};
        end
        S_TERMS: begin
          for (int a = 0; a < 3; a++) begin
            p_t[a]   <= p_c[a];
            i_acc[a] <= int_en ? i_c[a] : '0;
            d_t[a]   <= d_c[a];
          end
        end
        S_SUM: begin
          for (int a = 0; a < 3; a++)
            u[a] <= p_t[a] + i_acc[a] + d_t[a];
        end
        S_LIMIT: begin
          for (int a = 0; a < 3; a++) begin
            axis_q[a] <= sat16(u[a]);
            e_prev[a] <= err[a];
          end
          if (thr_x < 0)
            throttle_out <= '0;
          else if (thr_x > TMAX)
            throttle_out <= 16'(TMAX);
          else
            throttle_out <= thr_l;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/body_rate_controller.md
Name: body_rate_controller

Overview:
- Downstream stage of the angle controller. Consumes its limited throttle/yaw/pitch/roll rate targets (16-bit, 2's complement, 12.4 fixed point) and the IMU body rates.
- Runs one PI(D) iteration per start request and produces limited per-axis rate commands for the motor mixer.
- Handshake: start/active/complete, the same scheme used by the upstream stage.

Parameters:
KP_MULT, 8, proportional multiplier
KP_SHIFT, 3, proportional arithmetic right shift (default gain 1.0)
KI_MULT, 1, integral multiplier
KI_SHIFT, 6, integral arithmetic right shift (default gain 1/64)
KD_MULT, 0, derivative multiplier (0 disables D)
KD_SHIFT, 0, derivative arithmetic right shift
INT_LIMIT, 2000, integrator magnitude clamp (12.4 units)
OUT_LIMIT, 4000, axis output magnitude clamp (12.4 units)
THROTTLE_MAX, 4000, throttle upper clamp
INT_EN_THROTTLE, 480, throttle below this clears and freezes all integrators

Ports:
us_clk  input  1  system clock
resetn  input  1  asynchronous, active-low reset
start_signal  input  1  compute request (level; rising edge triggers)
throttle_rate_in  input  16  signed throttle target
yaw_rate_target  input  16  signed 12.4 deg/s
pitch_rate_target  input  16  signed 12.4 deg/s
roll_rate_target  input  16  signed 12.4 deg/s
yaw_rate_actual  input  16  signed 12.4 IMU rate
pitch_rate_actual  input  16  signed 12.4 IMU rate
roll_rate_actual  input  16  signed 12.4 IMU rate
throttle_out  output  16  limited throttle
yaw_out  output  16  limited yaw command
pitch_out  output  16  limited pitch command
roll_out  output  16  limited roll command
active_signal  output  1  computation in progress
complete_signal  output  1  one-cycle done pulse

Behaviour:
- Reset (async, any state, including mid-computation):
  - All outputs 0.
  - State WAIT.
  - Pending flag, integrators, previous errors and start-edge register cleared.
- Start detect: rising edge means start_signal=1 now and 0 on the previous us_clk edge.
  - In WAIT: go to LATCH.
  - In any other state: set a one-deep pending flag. Further edges while pending are dropped.
- States, one cycle each: WAIT -> LATCH -> ERROR -> TERMS -> SUM -> LIMIT -> COMPLETE -> WAIT (or -> LATCH if pending, which clears pending).
- LATCH: register all seven data inputs. Later input changes do not affect this run.
- ERROR: e = target - actual per axis, sign-extended to 32 bits before subtracting (no 16-bit overflow).
- TERMS, all 32-bit signed:
  - p = (e*KP_MULT) >>> KP_SHIFT
  - i = sat(i + ((e*KI_MULT) >>> KI_SHIFT), -INT_LIMIT, +INT_LIMIT)
  - d = ((e - e_prev)*KD_MULT) >>> KD_SHIFT
  - If latched throttle < INT_EN_THROTTLE, i is forced to 0 instead.
- SUM: u = p + i + d, 32-bit.
- LIMIT:
  - Axis outputs = clamp(u, -OUT_LIMIT, +OUT_LIMIT)[15:0].
  - throttle_out = clamp(latched throttle, 0, THROTTLE_MAX).
  - e_prev <= e.
  - complete_signal <= 1 on the same edge.
- Outputs hold their values between runs.
- Timing:
  - Edge that samples start = E0.
  - active_signal is 1 after E0 through E5, 0 otherwise.
  - Outputs update and complete_signal rises at E5. complete_signal falls at E6, so it is exactly one cycle wide.
  - Back-to-back pending run: LATCH at E6, next complete at E11.
- Boundaries:
  - Clamp comparisons are inclusive: |u| = OUT_LIMIT passes unchanged.
  - Integrator saturates and holds at the limit; it never wraps.
  - Negative shifts round toward -infinity (arithmetic shift).
  - First run after reset uses e_prev = 0.

Test Plan:
- Reset mid-run (assert resetn=0 in SUM) -> all outputs 0, active=0, complete=0; next start runs normally with integrators at 0.
- Defaults; throttle 1600, pitch target 160, actual 0, one start -> pitch_out=162 (p 160 + i 2), yaw_out=roll_out=0, throttle_out=1600, complete high exactly one cycle at E5.
- Roll target -1600, actual 0, throttle 1600 -> roll_out=-1625 (i = -25 via arithmetic shift).
- Pitch target 4000, actual -4000, throttle 1600, 20 runs -> pitch_out=4000 every run; integrator steps by 125, reaches 2000 at run 16 and holds (checked via KP_MULT=0 build: pitch_out=125, 250 … 2000, 2000).
- Throttle 400 (<480) after windup -> integrators cleared, pitch_out equals p only; throttle 5000 -> throttle_out=4000; throttle -16 -> 0.
- Second start edge at E2 -> exactly two complete pulses (E5, E11), second run uses inputs latched at E6; a third edge at E3 is dropped.
